// File: rtl/interrupt_pkg.sv
// Shared constants, register map and FSM states
// for the vectored interrupt controller.
package interrupt_pkg;

  localparam int          NUM_SRC       = 8;
  localparam logic [15:0] VECTOR_BASE   = 16'hFF00;
  localparam logic [15:0] VECTOR_STRIDE = 16'h0010;

  localparam logic [1:0] REG_MASK    = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_ACTIVE  = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Handler address, 16-bit wrap-around arithmetic.
  function automatic logic [15:0] vec_addr(
    input logic [15:0] base,
    input logic [15:0] stride,
    input logic [15:0] id
  );
    return base + id * stride;
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational lowest-index-wins encoder
// over the eligible interrupt requests.
module irq_priority_encoder #(
  parameter int N    = 8,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    req,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  // Scan downward so the lowest set index is the last assignment.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered vectored interrupt controller:
// mask/pending/GIE registers and a REQ/ack FSM.
module interrupt_controller #(
  parameter int          NUM_SRC       = interrupt_pkg::NUM_SRC,
  parameter logic [15:0] VECTOR_BASE   = interrupt_pkg::VECTOR_BASE,
  parameter logic [15:0] VECTOR_STRIDE = interrupt_pkg::VECTOR_STRIDE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq,
  output logic [15:0]        irq_vector,
  input  logic               reset_irq,
  input  logic               reg_write,
  input  logic [1:0]         reg_addr,
  input  logic [15:0]        reg_wdata,
  output logic [15:0]        reg_rdata
);

  import interrupt_pkg::*;

  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t             state;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic               gie;
  logic [ID_W-1:0]    active_id;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] wr_clr;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] pending_n;
  logic [NUM_SRC-1:0] mask_n;
  logic               gie_n;
  logic               ack;
  logic [ID_W-1:0]    win_id;
  logic               win_vld;
  logic               unused_ok;

  assign unused_ok = &{1'b0, reg_wdata};

  assign ack      = (state == REQ) && reset_irq;
  assign rise     = src & ~src_q;
  assign eligible = pending & mask & {NUM_SRC{gie}};

  irq_priority_encoder #(
    .N    (NUM_SRC),
    .ID_W (ID_W)
  ) u_enc (
    .req   (eligible),
    .id    (win_id),
    .valid (win_vld)
  );

  // Next-state of the bus registers; new edges beat any clear.
  always_comb begin
    wr_clr  = '0;
    ack_clr = '0;
    mask_n  = mask;
    gie_n   = gie;
    if (reg_write && reg_addr == REG_PENDING)
      wr_clr = reg_wdata[NUM_SRC-1:0];
    if (ack)
      ack_clr = {{(NUM_SRC-1){1'b0}}, 1'b1} << active_id;
    if (reg_write && reg_addr == REG_MASK)
      mask_n = reg_wdata[NUM_SRC-1:0];
    if (reg_write && reg_addr == REG_CTRL)
      gie_n = reg_wdata[0];
    else if (ack)
      gie_n = 1'b0;
    pending_n = (pending & ~(wr_clr | ack_clr)) | rise;
  end

  // Register file and edge-detect state.
  always_ff @(posedge clock) begin
    if (reset) begin
      src_q   <= '0;
      mask    <= '0;
      pending <= '0;
      gie     <= 1'b0;
    end else begin
      src_q   <= src;
      mask    <= mask_n;
      pending <= pending_n;
      gie     <= gie_n;
    end
  end

  // Request FSM; the latched request holds until acknowledged.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      irq        <= 1'b0;
      active_id  <= '0;
      irq_vector <= VECTOR_BASE;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            state      <= REQ;
            irq        <= 1'b1;
            active_id  <= win_id;
            irq_vector <= vec_addr(VECTOR_BASE, VECTOR_STRIDE,
                                   {{(16-ID_W){1'b0}}, win_id});
          end
        end
        REQ: begin
          if (reset_irq) begin
            state      <= IDLE;
            irq        <= 1'b0;
            irq_vector <= VECTOR_BASE;
          end
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

  // Combinational register read-back.
  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr)
      REG_MASK:    reg_rdata[NUM_SRC-1:0] = mask;
      REG_PENDING: reg_rdata[NUM_SRC-1:0] = pending;
      REG_CTRL:    reg_rdata[0] = gie;
      REG_ACTIVE: begin
        reg_rdata[15]       = (state == REQ);
        reg_rdata[ID_W-1:0] = active_id;
      end
      default:     reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scoreboard bench for interrupt_controller.
// Inputs change on negedge; outputs sampled before next posedge.
module tb_interrupt_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  src;
  logic        irq;
  logic [15:0] irq_vector;
  logic        reset_irq;
  logic        reg_write;
  logic [1:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  interrupt_controller dut (
    .clock      (clock),
    .reset      (reset),
    .src        (src),
    .irq        (irq),
    .irq_vector (irq_vector),
    .reset_irq  (reset_irq),
    .reg_write  (reg_write),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push(input string t, input logic [15:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty got %h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s got %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic chk_irq(input string t, input logic exp_irq);
    push(t, {15'd0, exp_irq});
    pop_chk({15'd0, irq});
  endtask

  task automatic chk_vec(input string t, input logic [15:0] v);
    push(t, v);
    pop_chk(irq_vector);
  endtask

  task automatic chk_reg(input string t, input logic [1:0] a,
                         input logic [15:0] v);
    logic [15:0] d;
    push(t, v);
    reg_addr = a;
    #1;
    d = reg_rdata;
    pop_chk(d);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    reg_write = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    step();
    reg_write = 1'b0;
  endtask

  task automatic ack();
    reset_irq = 1'b1;
    step();
    reset_irq = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    src       = '0;
    reset_irq = 1'b0;
    reg_write = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    @(negedge clock);
    step();
    step();
    reset = 1'b0;

    chk_irq("rst_irq", 1'b0);
    chk_vec("rst_vec", 16'hFF00);
    chk_reg("rst_mask", 2'd0, 16'h0000);
    chk_reg("rst_pend", 2'd1, 16'h0000);
    chk_reg("rst_ctrl", 2'd2, 16'h0000);
    chk_reg("rst_act", 2'd3, 16'h0000);

    // Single source 0
    wr(2'd0, 16'h0001);
    wr(2'd2, 16'h0001);
    src = 8'h01;
    step();
    src = 8'h00;
    chk_reg("s0_pend", 2'd1, 16'h0001);
    chk_irq("s0_irq_lat", 1'b0);
    step();
    chk_irq("s0_irq", 1'b1);
    chk_vec("s0_vec", 16'hFF00);
    chk_reg("s0_act", 2'd3, 16'h8000);
    ack();
    chk_irq("s0_ack_irq", 1'b0);
    chk_reg("s0_ack_pend", 2'd1, 16'h0000);
    chk_reg("s0_ack_gie", 2'd2, 16'h0000);

    // Priority between 5 and 2, then back-to-back
    wr(2'd0, 16'h00FF);
    wr(2'd2, 16'h0001);
    src = 8'h24;
    step();
    src = 8'h00;
    step();
    chk_vec("pri_vec2", 16'hFF20);
    chk_reg("pri_act2", 2'd3, 16'h8002);
    ack();
    chk_reg("pri_pend", 2'd1, 16'h0020);
    chk_reg("pri_gie", 2'd2, 16'h0000);
    chk_irq("pri_irq0", 1'b0);
    step();
    chk_irq("pri_hold_off", 1'b0);
    wr(2'd2, 16'h0001);
    chk_irq("pri_gie_lat", 1'b0);
    step();
    chk_irq("pri_irq5", 1'b1);
    chk_vec("pri_vec5", 16'hFF50);
    ack();

    // Source 3: GIE latency, no retraction, write beats ack
    src = 8'h08;
    step();
    src = 8'h00;
    step();
    chk_irq("s3_noreq", 1'b0);
    wr(2'd2, 16'h0001);
    chk_irq("s3_lat0", 1'b0);
    step();
    chk_irq("s3_irq", 1'b1);
    chk_vec("s3_vec", 16'hFF30);
    wr(2'd0, 16'h0000);
    wr(2'd2, 16'h0000);
    wr(2'd1, 16'h0008);
    chk_irq("s3_hold_irq", 1'b1);
    chk_vec("s3_hold_vec", 16'hFF30);
    chk_reg("s3_hold_act", 2'd3, 16'h8003);
    reset_irq = 1'b1;
    wr(2'd2, 16'h0001);
    reset_irq = 1'b0;
    chk_irq("s3_ack_irq", 1'b0);
    chk_reg("s3_wr_wins", 2'd2, 16'h0001);
    chk_vec("s3_idle_vec", 16'hFF00);

    // Edge beats write-1-to-clear
    src = 8'h02;
    wr(2'd1, 16'h0002);
    chk_reg("w1c_set", 2'd1, 16'h0002);
    src = 8'h00;
    wr(2'd1, 16'h0002);
    chk_reg("w1c_clr", 2'd1, 16'h0000);

    // Edge beats acknowledge clear
    wr(2'd0, 16'h0001);
    src = 8'h01;
    step();
    src = 8'h00;
    step();
    chk_vec("ackset_vec", 16'hFF00);
    chk_irq("ackset_irq1", 1'b1);
    src = 8'h01;
    ack();
    src = 8'h00;
    chk_irq("ackset_irq0", 1'b0);
    chk_reg("ackset_pend", 2'd1, 16'h0001);
    wr(2'd1, 16'h0001);

    // Acknowledge in IDLE ignored
    wr(2'd2, 16'h0001);
    ack();
    chk_reg("idle_ack_gie", 2'd2, 16'h0001);
    chk_reg("idle_ack_act", 2'd3, 16'h0000);
    chk_irq("idle_ack_irq", 1'b0);

    // Reset during REQ
    wr(2'd0, 16'h00FF);
    src = 8'h40;
    step();
    src = 8'h00;
    step();
    chk_vec("r_vec6", 16'hFF60);
    reset = 1'b1;
    src   = 8'h80;
    step();
    reset = 1'b0;
    src   = 8'h00;
    chk_irq("r_irq", 1'b0);
    chk_vec("r_vec", 16'hFF00);
    chk_reg("r_mask", 2'd0, 16'h0000);
    chk_reg("r_pend", 2'd1, 16'h0000);
    chk_reg("r_ctrl", 2'd2, 16'h0000);
    chk_reg("r_act", 2'd3, 16'h0000);
    step();
    chk_reg("r_no_edge", 2'd1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NUM_SRC, default 8: number of interrupt sources.
REQ-002 Parameter VECTOR_BASE, default 16'hFF00: handler address of source 0.
REQ-003 Parameter VECTOR_STRIDE, default 16'h0010: address spacing between consecutive source handlers.
REQ-004 clock  input  1  sole clock; all state updates on posedge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 src  input  NUM_SRC  peripheral interrupt lines, already synchronous to clock, rising-edge triggered.
REQ-007 irq  output  1  interrupt request to the CPU control path.
REQ-008 irq_vector  output  16  handler address consumed by the CPU when it loads PC from the IRQ source.
REQ-009 reset_irq  input  1  acknowledge from the CPU; high for one cycle.
REQ-010 reg_write  input  1  register write strobe from the memory-mapped bus.
REQ-011 reg_addr  input  2  register select.
REQ-012 reg_wdata  input  16  write data.
REQ-013 reg_rdata  output  16  combinational read data for reg_addr.

Function
REQ-014 Register map; unused bits read 0:
- 0 MASK: R/W, bits NUM_SRC-1:0, 1 = enabled.
- 1 PENDING: read; writing 1 to a bit clears that bit.
- 2 CTRL: bit 0 GIE, R/W.
- 3 ACTIVE: read-only; bit 15 = request outstanding; bits 2:0 = latched source id.
REQ-015 A src_q register holds the previous src; pending[i] sets on the posedge where src[i]=1 and src_q[i]=0, independent of mask and GIE.
REQ-016 Setting has priority: an edge coinciding with a write-1-to-clear or an acknowledge clear of the same bit leaves that bit set.
REQ-017 A source is eligible when pending[i] & MASK[i] & GIE; the lowest-index eligible source wins.
REQ-018 The FSM has two states, IDLE and REQ.
REQ-019 IDLE -> REQ on the first posedge at which any source is eligible; the winning id is latched into active_id.
REQ-020 irq = (state == REQ), registered; irq rises one cycle after the pending bit becomes eligible, i.e. two posedges after the src edge when already enabled.
REQ-021 In REQ, irq_vector = VECTOR_BASE + active_id*VECTOR_STRIDE, computed at 16-bit width with wrap-around; the value is held stable for the whole REQ period.
REQ-022 In IDLE, irq_vector = VECTOR_BASE.
REQ-023 In REQ, reset_irq=1 on a posedge does three things: clears pending[active_id] (subject to REQ-016), clears GIE, and returns the FSM to IDLE.
REQ-024 The handler re-enables GIE by writing CTRL.
REQ-025 A reset_irq received in IDLE is ignored.
REQ-026 Once in REQ, the request is never retracted: clearing MASK, GIE or the pending bit does not deassert irq or change active_id until reset_irq.
REQ-027 A CTRL write with bit 0 = 1 in the same cycle as an acknowledge leaves GIE = 1 (the write wins).
REQ-028 Latency from GIE set with an eligible pending bit to irq = 1 is exactly 1 cycle.
REQ-029 Back-to-back service: after an acknowledge, no new REQ is possible until GIE is rewritten to 1.

Reset
REQ-030 While reset=1 at a posedge, the following all clear to 0: state IDLE, irq=0, MASK, PENDING, GIE, active_id, src_q.
REQ-031 Reset asserted mid-REQ drops irq on the next posedge; edges present during reset are not recorded.

Structure
REQ-032 Package interrupt_pkg holds NUM_SRC, VECTOR_BASE, VECTOR_STRIDE, the register address constants and the state enum.
REQ-033 Sub-module irq_priority_encoder (NUM_SRC-bit request in; id and valid out) is purely combinational.

Verification
REQ-034 Reset, then MASK=8'h01, GIE=1, pulse src[0] -> PENDING=1 next cycle; irq=1 the following cycle; irq_vector=16'hFF00; ACTIVE=16'h8000.
REQ-035 With MASK=8'hFF and GIE=1, raise src[5] and src[2] in the same cycle -> irq_vector=16'hFF20; acknowledge -> PENDING=8'h20, GIE=0, irq=0; write GIE=1 -> irq_vector=16'hFF50 one cycle later.
REQ-036 In REQ for source 3, write MASK=0 and GIE=0 -> irq stays 1 and irq_vector stays 16'hFF30 until reset_irq.
REQ-037 A src[1] edge in the same cycle as a PENDING write of 16'h0002 -> PENDING bit 1 remains 1.
REQ-038 reset_irq pulsed in IDLE -> no state change.
REQ-039 reset=1 asserted during REQ -> irq=0 and all registers 0 after one posedge.
